// File: rtl/sram_bus_arbiter.sv
// Two-master (inst/data) arbiter onto a single SRAM-style bus, one transaction in flight.
// Data wins ties unless it has starved inst for STARVE_LIMIT consecutive grants.
module sram_bus_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        resetn,

  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [3:0]  inst_wstrb,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,

  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,

  output logic        bus_req,
  output logic        bus_wr,
  output logic [1:0]  bus_size,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_addr_ok,
  input  logic        bus_data_ok,
  input  logic [31:0] bus_rdata
);

  localparam logic [2:0] Limit = 3'(STARVE_LIMIT);

  typedef enum logic [1:0] {StIdle, StAddr, StData} state_e;

  state_e     state_q, state_d;
  logic       grant_data_q, grant_data_d;
  logic [2:0] streak_q, streak_d;
  logic       pick_data;

  assign pick_data = data_req && (!inst_req || (streak_q < Limit));

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= StIdle;
      grant_data_q <= 1'b0;
      streak_q     <= 3'd0;
    end else begin
      state_q      <= state_d;
      grant_data_q <= grant_data_d;
      streak_q     <= streak_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_data_d = grant_data_q;
    streak_d     = streak_q;
    unique case (state_q)
      StIdle: begin
        if (inst_req || data_req) begin
          state_d      = StAddr;
          grant_data_d = pick_data;
          // Streak only counts data grants that actually made inst wait.
          if (pick_data && inst_req) begin
            streak_d = (streak_q < Limit) ? streak_q + 3'd1 : streak_q;
          end else begin
            streak_d = 3'd0;
          end
        end
      end
      StAddr: begin
        if (bus_addr_ok) state_d = StData;
      end
      StData: begin
        if (bus_data_ok) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs are gated by resetn so nothing leaks while reset is held mid-transaction.
  always_comb begin
    bus_req      = 1'b0;
    bus_wr       = 1'b0;
    bus_size     = 2'd0;
    bus_wstrb    = 4'd0;
    bus_addr     = 32'd0;
    bus_wdata    = 32'd0;
    inst_addr_ok = 1'b0;
    data_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    data_data_ok = 1'b0;
    if (resetn) begin
      if (state_q == StAddr) begin
        bus_req = 1'b1;
        if (grant_data_q) begin
          bus_wr    = data_wr;
          bus_size  = data_size;
          bus_wstrb = data_wstrb;
          bus_addr  = data_addr;
          bus_wdata = data_wdata;
        end else begin
          bus_wr    = inst_wr;
          bus_size  = inst_size;
          bus_wstrb = inst_wstrb;
          bus_addr  = inst_addr;
          bus_wdata = inst_wdata;
        end
        inst_addr_ok = bus_addr_ok && !grant_data_q;
        data_addr_ok = bus_addr_ok && grant_data_q;
      end
      if (state_q == StData) begin
        inst_data_ok = bus_data_ok && !grant_data_q;
        data_data_ok = bus_data_ok && grant_data_q;
      end
    end
  end

  assign inst_rdata = bus_rdata;
  assign data_rdata = bus_rdata;

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Self-checking bench: table of transaction vectors run against a cycle-timed slave model and
// an expected-transaction queue, plus hand sequences for starvation and mid-transaction reset.
module tb_sram_bus_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req, inst_wr, data_req, data_wr;
  logic [1:0]  inst_size, data_size;
  logic [3:0]  inst_wstrb, data_wstrb;
  logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic        bus_req, bus_wr;
  logic [1:0]  bus_size;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_addr, bus_wdata;
  logic        bus_addr_ok, bus_data_ok;
  logic [31:0] bus_rdata;

  always #5 clk = ~clk;

  sram_bus_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_wstrb(inst_wstrb),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size), .bus_wstrb(bus_wstrb),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_addr_ok(bus_addr_ok),
    .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata)
  );

  typedef struct {
    logic        i_en, d_en;
    logic        i_wr;
    logic [1:0]  i_size;
    logic [3:0]  i_wstrb;
    logic [31:0] i_addr, i_wdata;
    logic        d_wr;
    logic [1:0]  d_size;
    logic [3:0]  d_wstrb;
    logic [31:0] d_addr, d_wdata;
    logic [31:0] rdata;
    int          a_stall, d_stall;
  } vec_t;

  typedef struct {
    logic        is_data;
    logic [70:0] fields;
    logic [31:0] rdata;
    int          acyc, dcyc, astall;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_fail = 0;
  int   cyc;
  bit   hold = 1'b0;
  vec_t tbl[6];

  task automatic fail_line(string name, logic [70:0] act, logic [70:0] req);
    n_fail++;
    $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
  endtask

  task automatic chk1(string name, logic act, logic req);
    n_vec++;
    if (act !== req) fail_line(name, 71'(act), 71'(req));
  endtask

  task automatic chk32(string name, logic [31:0] act, logic [31:0] req);
    n_vec++;
    if (act !== req) fail_line(name, 71'(act), 71'(req));
  endtask

  task automatic chkw(string name, logic [70:0] act, logic [70:0] req);
    n_vec++;
    if (act !== req) fail_line(name, act, req);
  endtask

  function automatic vec_t mk(logic ie, logic de, logic iw, logic [1:0] isz, logic [3:0] istb,
                              logic [31:0] ia, logic [31:0] iwd, logic dw, logic [1:0] dsz,
                              logic [3:0] dstb, logic [31:0] da, logic [31:0] dwd,
                              logic [31:0] rd, int as, int ds);
    vec_t v;
    v.i_en = ie; v.d_en = de;
    v.i_wr = iw; v.i_size = isz; v.i_wstrb = istb; v.i_addr = ia; v.i_wdata = iwd;
    v.d_wr = dw; v.d_size = dsz; v.d_wstrb = dstb; v.d_addr = da; v.d_wdata = dwd;
    v.rdata = rd; v.a_stall = as; v.d_stall = ds;
    return v;
  endfunction

  function automatic logic [70:0] ifields(vec_t v);
    return {v.i_wr, v.i_size, v.i_wstrb, v.i_addr, v.i_wdata};
  endfunction

  function automatic logic [70:0] dfields(vec_t v);
    return {v.d_wr, v.d_size, v.d_wstrb, v.d_addr, v.d_wdata};
  endfunction

  // Expected timing: one IDLE cycle, ADDR for 1+a_stall cycles, DATA for 1+d_stall cycles.
  task automatic push(logic is_data, logic [70:0] f, logic [31:0] rd, int as, int ds,
                      inout int t);
    exp_t e;
    e.is_data = is_data; e.fields = f; e.rdata = rd; e.astall = as;
    e.acyc = t + 1 + as;
    e.dcyc = e.acyc + 1 + ds;
    t = e.dcyc + 1;
    q.push_back(e);
  endtask

  task automatic drive_masters(vec_t v);
    inst_req = v.i_en; inst_wr = v.i_wr; inst_size = v.i_size; inst_wstrb = v.i_wstrb;
    inst_addr = v.i_addr; inst_wdata = v.i_wdata;
    data_req = v.d_en; data_wr = v.d_wr; data_size = v.d_size; data_wstrb = v.d_wstrb;
    data_addr = v.d_addr; data_wdata = v.d_wdata;
  endtask

  // Entered at a negedge; the slave answers from the expected timeline, not from DUT outputs.
  task automatic do_cycle();
    exp_t e;
    logic in_addr, in_data, exp_aok, exp_dok;
    e = q[0];
    in_addr = (cyc >= e.acyc - e.astall) && (cyc <= e.acyc);
    in_data = (cyc > e.acyc) && (cyc <= e.dcyc);
    bus_addr_ok = in_addr && (cyc == e.acyc);
    bus_data_ok = in_data ? (cyc == e.dcyc) : 1'b1;
    bus_rdata = in_data ? e.rdata : 32'h0BAD_F00D;
    #1;
    exp_aok = bus_addr_ok;
    exp_dok = in_data && bus_data_ok;
    chk1("bus_req", bus_req, in_addr);
    chkw("bus_fields", {bus_wr, bus_size, bus_wstrb, bus_addr, bus_wdata},
         in_addr ? e.fields : 71'd0);
    chk1("inst_addr_ok", inst_addr_ok, exp_aok && !e.is_data);
    chk1("data_addr_ok", data_addr_ok, exp_aok && e.is_data);
    chk1("inst_data_ok", inst_data_ok, exp_dok && !e.is_data);
    chk1("data_data_ok", data_data_ok, exp_dok && e.is_data);
    if (exp_dok) chk32("rdata", e.is_data ? data_rdata : inst_rdata, e.rdata);
    if (exp_aok && !hold) begin
      if (e.is_data) data_req = 1'b0;
      else inst_req = 1'b0;
    end
    if (exp_dok) begin
      void'(q.pop_front());
      if (q.size() == 0) begin
        inst_req = 1'b0;
        data_req = 1'b0;
      end
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic run_queue();
    cyc = 0;
    while (q.size() > 0) do_cycle();
    bus_addr_ok = 1'b0;
    bus_data_ok = 1'b0;
  endtask

  task automatic run_vec(vec_t v);
    int t = 0;
    drive_masters(v);
    // With streak below the limit, data is served first when both ask.
    if (v.d_en) push(1'b1, dfields(v), v.rdata, v.a_stall, v.d_stall, t);
    if (v.i_en) push(1'b0, ifields(v), v.rdata ^ 32'h5A5A_5A5A, v.a_stall, v.d_stall, t);
    run_queue();
  endtask

  task automatic chk_idle_outputs(string tag);
    chk1({tag, "_bus_req"}, bus_req, 1'b0);
    chkw({tag, "_fields"}, {bus_wr, bus_size, bus_wstrb, bus_addr, bus_wdata}, 71'd0);
    chk1({tag, "_inst_addr_ok"}, inst_addr_ok, 1'b0);
    chk1({tag, "_data_addr_ok"}, data_addr_ok, 1'b0);
    chk1({tag, "_inst_data_ok"}, inst_data_ok, 1'b0);
    chk1({tag, "_data_data_ok"}, data_data_ok, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int   t;
    tbl[0] = mk(1, 0, 0, 2, 4'h0, 32'h1c00_0000, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0,
                32'h0280_0404, 0, 0);
    tbl[1] = mk(1, 1, 0, 2, 4'h0, 32'h1c00_0004, 32'h0, 1, 2, 4'hF, 32'h100, 32'hDEAD_BEEF,
                32'h1122_3344, 0, 0);
    tbl[2] = mk(0, 1, 0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 4'h0, 32'h203, 32'h0,
                32'h0000_00A5, 3, 2);
    tbl[3] = mk(1, 0, 1, 1, 4'h3, 32'h1c00_0010, 32'h0000_CAFE, 0, 0, 4'h0, 32'h0, 32'h0,
                32'h0, 1, 0);
    tbl[4] = mk(1, 1, 1, 2, 4'hF, 32'h1c00_0100, 32'h1234_5678, 0, 1, 4'h0, 32'h402, 32'h0,
                32'hA5A5_5A5A, 0, 3);
    tbl[5] = mk(0, 1, 0, 0, 4'h0, 32'h0, 32'h0, 1, 0, 4'h8, 32'h8000_0003, 32'hFF00_0000,
                32'h0, 2, 1);

    resetn = 1'b0;
    drive_masters(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = 32'h0;
    repeat (2) @(negedge clk);
    // Requests and slave handshakes during reset must not produce any output.
    inst_req = 1'b1; data_req = 1'b1; bus_addr_ok = 1'b1; bus_data_ok = 1'b1;
    #1;
    chk_idle_outputs("reset");
    @(negedge clk);
    inst_req = 1'b0; data_req = 1'b0; bus_addr_ok = 1'b0; bus_data_ok = 1'b0;
    resetn = 1'b1;
    #1;
    chk_idle_outputs("post_reset");
    @(negedge clk);

    for (int i = 0; i < 6; i++) run_vec(tbl[i]);

    // Starvation: both requests held throughout, expect D,D,D,D,I twice.
    v = tbl[1];
    hold = 1'b1;
    drive_masters(v);
    t = 0;
    for (int k = 0; k < 10; k++) begin
      if ((k % 5) == 4) push(1'b0, ifields(v), 32'h1000 + k, 0, 0, t);
      else push(1'b1, dfields(v), 32'h2000 + k, 0, 0, t);
    end
    run_queue();
    hold = 1'b0;

    // Reset asserted during DATA, then a late bus_data_ok.
    drive_masters(mk(1, 0, 0, 2, 4'h0, 32'h1c00_0020, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0));
    #1;
    chk1("rst_seq_idle_bus_req", bus_req, 1'b0);
    @(negedge clk);
    bus_addr_ok = 1'b1;
    #1;
    chk1("rst_seq_addr_ok", inst_addr_ok, 1'b1);
    inst_req = 1'b0;
    @(negedge clk);
    bus_addr_ok = 1'b0;
    #1;
    chk1("rst_seq_data_phase_bus_req", bus_req, 1'b0);
    resetn = 1'b0;
    bus_data_ok = 1'b1;
    #1;
    chk_idle_outputs("rst_in_data");
    @(negedge clk);
    resetn = 1'b1;
    #1;
    chk_idle_outputs("rst_late_data_ok");
    @(negedge clk);
    bus_data_ok = 1'b0;
    #1;
    chk_idle_outputs("rst_settled");
    @(negedge clk);
    run_vec(tbl[1]);
    run_vec(tbl[0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
